// File: rtl/serial_read_buffer.sv
// Serial read buffer: shifts BUF_SIZE bits in MSB first on read_sig strobes and presents the word with a valid pulse.
// Optional input synchronizer enabled by defining SERIAL_READ_SYNC_EN.
module serial_read_buffer #(
  parameter int BUF_SIZE = 8
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                read_sig,
  input  logic                abort,
  input  logic                data_in,
  output logic [BUF_SIZE-1:0] data_out,
  output logic                valid,
  output logic                busy
);

  localparam int CW = $clog2(BUF_SIZE + 1);
  localparam logic [CW-1:0] CTR_FULL = CW'(BUF_SIZE);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [BUF_SIZE-1:0] read_buf_r, read_buf_s;
  logic [CW-1:0]       buf_ctr_r, buf_ctr_s;
  logic [BUF_SIZE-1:0] data_out_r, data_out_s;
  logic                valid_r, valid_s;
  logic                busy_r, busy_s;
  logic                sample_s;
  logic [BUF_SIZE-1:0] shifted_s;

`ifdef SERIAL_READ_SYNC_EN
  logic sync1_r, sync2_r;

  // Two-stage synchronizer on the serial line
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= data_in;
      sync2_r <= sync1_r;
    end
  end

  assign sample_s = sync2_r;
`else
  assign sample_s = data_in;
`endif

  generate
    if (BUF_SIZE == 1) begin : g_shift_one
      assign shifted_s = sample_s;
    end else begin : g_shift_wide
      assign shifted_s = {read_buf_r[BUF_SIZE-2:0], sample_s};
    end
  endgenerate

  // State and datapath registers; reset parks the block in RESET with busy held high
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r    <= ST_RESET;
      read_buf_r <= {BUF_SIZE{1'b0}};
      buf_ctr_r  <= {CW{1'b0}};
      data_out_r <= {BUF_SIZE{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      read_buf_r <= read_buf_s;
      buf_ctr_r  <= buf_ctr_s;
      data_out_r <= data_out_s;
      valid_r    <= valid_s;
      busy_r     <= busy_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    read_buf_s = read_buf_r;
    buf_ctr_s  = buf_ctr_r;
    data_out_s = data_out_r;
    valid_s    = 1'b0;
    busy_s     = busy_r;
    case (state_r)
      ST_RESET: begin
        read_buf_s = {BUF_SIZE{1'b0}};
        buf_ctr_s  = {CW{1'b0}};
        busy_s     = 1'b0;
        state_s    = ST_IDLE;
      end
      ST_IDLE: begin
        if (start) begin
          read_buf_s = {BUF_SIZE{1'b0}};
          buf_ctr_s  = {CW{1'b0}};
          busy_s     = 1'b1;
          state_s    = ST_READ;
        end else begin
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        // Abort outranks completion, which outranks a strobe in the same cycle
        if (abort) begin
          state_s = ST_DONE;
        end else if (buf_ctr_r == CTR_FULL) begin
          data_out_s = read_buf_r;
          valid_s    = 1'b1;
          state_s    = ST_DONE;
        end else if (read_sig) begin
          read_buf_s = shifted_s;
          buf_ctr_s  = buf_ctr_r + CW'(1);
          state_s    = ST_READ;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DONE: begin
        read_buf_s = {BUF_SIZE{1'b0}};
        buf_ctr_s  = {CW{1'b0}};
        busy_s     = 1'b0;
        state_s    = ST_IDLE;
      end
      default: begin
        read_buf_s = {BUF_SIZE{1'b0}};
        buf_ctr_s  = {CW{1'b0}};
        busy_s     = 1'b1;
        state_s    = ST_RESET;
      end
    endcase
  end

  assign data_out = data_out_r;
  assign valid    = valid_r;
  assign busy     = busy_r;

endmodule
